// File: rtl/izh_scheduler.sv
// izh_scheduler: runs one shared Izhikevich update core over N_NEURONS virtual
// neurons. On each tick it issues each neuron to the core in turn and writes
// back the result. It then publishes the spike vector of the completed step.
module izh_scheduler #(
  parameter int unsigned    N_NEURONS = 4,
  parameter int unsigned    V_W       = 8,
  parameter int unsigned    U_W       = 8,
  parameter int unsigned    I_W       = 8,
  parameter logic [V_W-1:0] V_INIT    = '0,
  parameter logic [U_W-1:0] U_INIT    = '0,
  parameter int unsigned    TIMEOUT   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [I_W-1:0]               cfg_data,
  input  logic [$clog2(N_NEURONS)-1:0] obs_sel,
  output logic [V_W-1:0]               obs_v,
  output logic                         core_start,
  output logic [V_W-1:0]               core_v_in,
  output logic [U_W-1:0]               core_u_in,
  output logic [I_W-1:0]               core_i,
  input  logic                         core_done,
  input  logic [V_W-1:0]               core_v_out,
  input  logic [U_W-1:0]               core_u_out,
  input  logic                         core_spike,
  output logic [N_NEURONS-1:0]         spikes,
  output logic                         step_done,
  output logic                         busy,
  output logic                         err_timeout,
  output logic                         err_overrun,
  input  logic                         err_clr
);

  localparam int unsigned AW = $clog2(N_NEURONS);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 skip_q, skip_d;
  logic [V_W-1:0]       cap_v_q, cap_v_d;
  logic [U_W-1:0]       cap_u_q, cap_u_d;
  logic                 cap_spk_q, cap_spk_d;
  logic [N_NEURONS-1:0] spike_acc_q, spike_acc_d;
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic [V_W-1:0]       op_v_q, op_v_d;
  logic [U_W-1:0]       op_u_q, op_u_d;
  logic [I_W-1:0]       op_i_q, op_i_d;
  logic                 err_to_q, err_to_d;
  logic                 err_ov_q, err_ov_d;
  logic                 wb_en, to_set, ov_set;

  logic [V_W-1:0] v_mem_q   [N_NEURONS];
  logic [U_W-1:0] u_mem_q   [N_NEURONS];
  logic [I_W-1:0] cur_mem_q [N_NEURONS];

  // Sequencer next-state: issue, wait with timeout, write back, publish.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    skip_d      = skip_q;
    cap_v_d     = cap_v_q;
    cap_u_d     = cap_u_q;
    cap_spk_d   = cap_spk_q;
    spike_acc_d = spike_acc_q;
    spikes_d    = spikes_q;
    op_v_d      = op_v_q;
    op_u_d      = op_u_q;
    op_i_d      = op_i_q;
    wb_en       = 1'b0;
    to_set      = 1'b0;
    ov_set      = tick && (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d     = S_ISSUE;
          idx_d       = '0;
          spike_acc_d = '0;
          op_v_d      = v_mem_q[idx_d];
          op_u_d      = u_mem_q[idx_d];
          op_i_d      = cur_mem_q[idx_d];
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (core_done) begin
          cap_v_d   = core_v_out;
          cap_u_d   = core_u_out;
          cap_spk_d = core_spike;
          skip_d    = 1'b0;
          state_d   = S_WB;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          skip_d  = 1'b1;
          to_set  = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        wb_en              = !skip_q;
        spike_acc_d[idx_q] = !skip_q && cap_spk_q;
        if (idx_q == AW'(N_NEURONS - 1)) begin
          // Publish together with the last neuron's bit so spikes is valid in DONE.
          spikes_d = spike_acc_d;
          state_d  = S_DONE;
        end else begin
          // Operands for the next neuron are read from a different entry than
          // the one being written back on the same edge.
          idx_d   = idx_q + 1'b1;
          op_v_d  = v_mem_q[idx_d];
          op_u_d  = u_mem_q[idx_d];
          op_i_d  = cur_mem_q[idx_d];
          state_d = S_ISSUE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new set event in the same cycle as err_clr leaves the flag set.
    err_to_d = to_set || (err_to_q && !err_clr);
    err_ov_d = ov_set || (err_ov_q && !err_clr);
  end

  // Control, operand and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      skip_q      <= 1'b0;
      cap_v_q     <= '0;
      cap_u_q     <= '0;
      cap_spk_q   <= 1'b0;
      spike_acc_q <= '0;
      spikes_q    <= '0;
      op_v_q      <= '0;
      op_u_q      <= '0;
      op_i_q      <= '0;
      err_to_q    <= 1'b0;
      err_ov_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      cap_v_q     <= cap_v_d;
      cap_u_q     <= cap_u_d;
      cap_spk_q   <= cap_spk_d;
      spike_acc_q <= spike_acc_d;
      spikes_q    <= spikes_d;
      op_v_q      <= op_v_d;
      op_u_q      <= op_u_d;
      op_i_q      <= op_i_d;
      err_to_q    <= err_to_d;
      err_ov_q    <= err_ov_d;
    end
  end

  // Per-neuron state arrays: write-back of core results and current config.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        v_mem_q[k]   <= V_INIT;
        u_mem_q[k]   <= U_INIT;
        cur_mem_q[k] <= '0;
      end
    end else begin
      if (cfg_we) cur_mem_q[cfg_addr] <= cfg_data;
      if (wb_en) begin
        v_mem_q[idx_q] <= cap_v_q;
        u_mem_q[idx_q] <= cap_u_q;
      end
    end
  end

  assign obs_v       = v_mem_q[obs_sel];
  assign core_start  = (state_q == S_ISSUE);
  assign core_v_in   = op_v_q;
  assign core_u_in   = op_u_q;
  assign core_i      = op_i_q;
  assign spikes      = spikes_q;
  assign step_done   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_izh_scheduler.sv
// tb_izh_scheduler: drives izh_scheduler with a behavioural core model.
// Expected results come from a per-step arithmetic reference model.
module tb_izh_scheduler;
  localparam int N  = 4;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset, tick, cfg_we, err_clr;
  logic [1:0]   cfg_addr, obs_sel;
  logic [7:0]   cfg_data, obs_v;
  logic         core_start, core_done, core_spike;
  logic [7:0]   core_v_in, core_u_in, core_i, core_v_out, core_u_out;
  logic [N-1:0] spikes;
  logic         step_done, busy, err_timeout, err_overrun;

  izh_scheduler #(.N_NEURONS(N), .V_W(8), .U_W(8), .I_W(8),
                  .V_INIT(8'd0), .U_INIT(8'd0), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .obs_sel(obs_sel), .obs_v(obs_v), .core_start(core_start),
    .core_v_in(core_v_in), .core_u_in(core_u_in), .core_i(core_i),
    .core_done(core_done), .core_v_out(core_v_out), .core_u_out(core_u_out),
    .core_spike(core_spike), .spikes(spikes), .step_done(step_done), .busy(busy),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] mv[N], mu[N], mcur[N];
  bit         me_to, me_ov;

  // Core model controls and observed operands.
  int         lat;
  int         drop_idx;
  logic [7:0] seen_v[N], seen_u[N], seen_i[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Core model: done L cycles after the start cycle, v+i, u+1, spike on v>=100.
  initial begin
    int start_cnt;
    int nid;
    logic [7:0] vo;
    start_cnt  = 0;
    core_done  = 1'b0;
    core_v_out = '0;
    core_u_out = '0;
    core_spike = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) start_cnt = 0;
      else if (core_start) begin
        nid = start_cnt;
        start_cnt = (start_cnt + 1) % N;
        seen_v[nid] = core_v_in;
        seen_u[nid] = core_u_in;
        seen_i[nid] = core_i;
        if (nid != drop_idx) begin
          vo = core_v_in + core_i;
          for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            if (reset) start_cnt = 0;
          end
          core_done  = 1'b1;
          core_v_out = vo;
          core_u_out = core_u_in + 8'd1;
          core_spike = (vo >= 8'd100);
          @(negedge clk);
          core_done = 1'b0;
          if (reset) start_cnt = 0;
        end
      end
    end
  end

  task automatic write_cur(input int n, input int val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 2'(n); cfg_data = 8'(val);
    @(negedge clk);
    cfg_we = 1'b0;
    mcur[n] = 8'(val);
  endtask

  // One simulation step; mid_kind 1 = stray tick + err_clr, 2 = cur[0]=50 write.
  task automatic run_step(input int drop, input bit pre, input int mid_cyc,
                          input int mid_kind, input bit chain);
    logic [7:0]   ev[N], eu[N], ei[N];
    logic [N-1:0] esp;
    int           explat, cyc;
    explat = 1;
    for (int n = 0; n < N; n++) begin
      ev[n] = mv[n]; eu[n] = mu[n]; ei[n] = mcur[n];
      if (n == drop) begin
        esp[n] = 1'b0;
        explat += TO + 2;
      end else begin
        mv[n]  = mv[n] + mcur[n];
        mu[n]  = mu[n] + 8'd1;
        esp[n] = (mv[n] >= 8'd100);
        explat += lat + 2;
      end
    end
    if (mid_kind == 1) begin me_to = 1'b0; me_ov = 1'b1; end
    if (drop >= 0) me_to = 1'b1;
    drop_idx = drop;
    @(negedge clk);
    if (!pre) tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc = 1;
    while (!step_done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      tick = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
      if (cyc == mid_cyc && mid_kind == 1) begin tick = 1'b1; err_clr = 1'b1; end
      if (cyc == mid_cyc && mid_kind == 2) begin
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd50;
      end
    end
    check("step_latency", cyc, explat);
    check("busy_in_done", busy, 1);
    check("spikes", spikes, esp);
    check("err_timeout", err_timeout, me_to);
    check("err_overrun", err_overrun, me_ov);
    for (int n = 0; n < N; n++) begin
      obs_sel = 2'(n);
      #1;
      check($sformatf("obs_v[%0d]", n), obs_v, mv[n]);
      check($sformatf("op_v[%0d]", n), seen_v[n], ev[n]);
      check($sformatf("op_u[%0d]", n), seen_u[n], eu[n]);
      check($sformatf("op_i[%0d]", n), seen_i[n], ei[n]);
    end
    if (mid_kind == 2) mcur[0] = 8'd50;
    if (chain) begin
      tick  = 1'b1;
      me_ov = 1'b1;
    end
  endtask

  task automatic clear_errors();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    me_to = 1'b0; me_ov = 1'b0;
    check("clr_timeout", err_timeout, 0);
    check("clr_overrun", err_overrun, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act;
    int drop;
    reset = 1'b1; tick = 1'b0; cfg_we = 1'b0; err_clr = 1'b0;
    cfg_addr = '0; cfg_data = '0; obs_sel = '0;
    lat = 2; drop_idx = -1;
    for (int n = 0; n < N; n++) begin mv[n] = 0; mu[n] = 0; mcur[n] = 0; end
    me_to = 1'b0; me_ov = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_spikes", spikes, 0);
    check("rst_start", core_start, 0);
    check("rst_step_done", step_done, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_overrun", err_overrun, 0);
    reset = 1'b0;

    // Directed steps with L=2
    write_cur(0, 10); write_cur(1, 20); write_cur(2, 30); write_cur(3, 60);
    run_step(-1, 0, 0, 0, 0);
    run_step(-1, 0, 0, 0, 0);
    run_step(-1, 0, 0, 0, 0);

    // Neuron 1 never completes
    run_step(1, 0, 0, 0, 0);
    clear_errors();

    // Stray tick with err_clr in cycle 5: set wins, no second step
    run_step(-1, 0, 5, 1, 0);
    act = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || step_done) act++;
    end
    check("no_second_step", act, 0);
    clear_errors();

    // Current write while neuron 0 waits; next step (ticked in DONE and IDLE) uses it
    run_step(-1, 0, 2, 2, 0);
    run_step(-1, 0, 0, 0, 1);
    run_step(-1, 1, 0, 0, 0);
    clear_errors();

    // Reset during WAIT of neuron 2 with a slow core
    lat = 6;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (18) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_spikes", spikes, 0);
    check("mid_rst_start", core_start, 0);
    for (int n = 0; n < N; n++) begin
      obs_sel = 2'(n);
      #1;
      check($sformatf("mid_rst_v[%0d]", n), obs_v, 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < N; n++) begin mv[n] = 0; mu[n] = 0; mcur[n] = 0; end
    me_to = 1'b0; me_ov = 1'b0;
    repeat (10) @(negedge clk);
    check("late_done_busy", busy, 0);
    check("late_done_spikes", spikes, 0);
    for (int n = 0; n < N; n++) begin
      obs_sel = 2'(n);
      #1;
      check($sformatf("late_done_v[%0d]", n), obs_v, 0);
    end
    lat = 2;
    write_cur(0, 70); write_cur(1, 5); write_cur(2, 120); write_cur(3, 33);
    run_step(-1, 0, 0, 0, 0);

    // Randomized steps: currents, core latency and dropped neuron
    for (int r = 0; r < 8; r++) begin
      lat = int'($urandom_range(1, 4));
      for (int n = 0; n < N; n++) write_cur(n, int'($urandom_range(0, 255)));
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_step(drop, 0, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
